// File: rtl/aes_pkg.sv
// AES shared definitions: sizes, FSM encoding and GF(2^8) helpers.
// Used by both the cipher and inverse-cipher datapaths.
package aes_pkg;

  localparam int AES_NR    = 10;
  localparam int AES_BLK_W = 128;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ROUND = 2'd1,
    S_FINAL = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  function automatic logic [7:0] xtime(
    input logic [7:0] b
  );
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Shift-and-add multiply, reduced mod 0x11B.
  function automatic logic [7:0] gf_mul(
    input logic [7:0] a,
    input logic [7:0] k
  );
    logic [7:0] acc;
    logic [7:0] p;
    acc = 8'h00;
    p   = a;
    for (int i = 0; i < 8; i++) begin
      if (k[i]) acc = acc ^ p;
      p = xtime(p);
    end
    return acc;
  endfunction

endpackage

// File: rtl/inv_sub_box.sv
// Inverse AES S-box, one byte, pure table lookup.
// Sixteen copies cover a full block per cycle.
module inv_sub_box (
  input  logic [7:0] a,
  output logic [7:0] y
);

  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38,
    8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87,
    8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d,
    8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2,
    8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16,
    8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda,
    8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a,
    8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02,
    8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea,
    8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85,
    8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89,
    8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20,
    8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31,
    8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d,
    8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0,
    8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26,
    8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  assign y = INV_SBOX[a];

endmodule

// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES-128 inverse cipher, one round per clock.
// Round keys come combinationally from an external store via rk_idx.
module aes_inv_cipher_iter
  import aes_pkg::*;
#(
  parameter int NR    = AES_NR,
  parameter int BLK_W = AES_BLK_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [BLK_W-1:0] data_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BLK_W-1:0] data_out,
  output logic [3:0]       rk_idx,
  input  logic [BLK_W-1:0] rk_data,
  output logic             busy
);

  localparam logic [3:0] RND_LAST = 4'(NR - 1);
  localparam logic [3:0] KEY_LAST = 4'(NR);

  state_e           state;
  state_e           state_n;
  logic [3:0]       rnd;
  logic [BLK_W-1:0] st;
  logic [BLK_W-1:0] sr;
  logic [BLK_W-1:0] sb;
  logic [BLK_W-1:0] ark;
  logic [BLK_W-1:0] imc;

  function automatic logic [31:0] inv_mix_col(
    input logic [31:0] a
  );
    logic [7:0] a0, a1, a2, a3;
    logic [7:0] b0, b1, b2, b3;
    a0 = a[7:0];
    a1 = a[15:8];
    a2 = a[23:16];
    a3 = a[31:24];
    b0 = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b)
       ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
    b1 = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e)
       ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
    b2 = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09)
       ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
    b3 = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d)
       ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
    return {b3, b2, b1, b0};
  endfunction

  // Row r rotates right by r: out[r,c] = in[r,(c-r) mod 4].
  always_comb begin
    sr = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        sr[8*(4*c+r) +: 8] =
          st[8*(4*((c-r+4)%4)+r) +: 8];
      end
    end
  end

  for (genvar g = 0; g < 16; g++) begin : g_box
    inv_sub_box u_box (
      .a (sr[8*g +: 8]),
      .y (sb[8*g +: 8])
    );
  end

  assign ark = sb ^ rk_data;

  always_comb begin
    imc = '0;
    for (int c = 0; c < 4; c++) begin
      imc[32*c +: 32] = inv_mix_col(ark[32*c +: 32]);
    end
  end

  always_comb begin
    state_n   = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    rk_idx    = 4'd0;
    unique case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        rk_idx   = KEY_LAST;
        if (in_valid) state_n = S_ROUND;
      end
      S_ROUND: begin
        rk_idx = rnd;
        if (rnd == 4'd1) state_n = S_FINAL;
      end
      S_FINAL: state_n = S_DONE;
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      st    <= '0;
      rnd   <= RND_LAST;
    end else begin
      state <= state_n;
      unique case (state)
        S_IDLE: begin
          if (in_valid) begin
            st  <= data_in ^ rk_data;
            rnd <= RND_LAST;
          end
        end
        S_ROUND: begin
          st  <= imc;
          rnd <= rnd - 4'd1;
        end
        S_FINAL: st <= ark;
        default: ;
      endcase
    end
  end

  // st is frozen in DONE, so it doubles as the output register.
  assign data_out = st;

endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// Bench for aes_inv_cipher_iter: known-answer vectors, handshakes, reset.
// Round keys are expanded here from the cipher key.
module tb_aes_inv_cipher_iter;

  localparam logic [127:0] KEY1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT0  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
  localparam logic [127:0] PT0  = 128'h0;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] data_in = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] data_out;
  logic [3:0]   rk_idx;
  logic [127:0] rk_data;
  logic         busy;

  int checks = 0;
  int errors = 0;
  int acc_cnt = 0;
  int ohs_cnt = 0;

  logic [127:0] exp_q[$];
  logic [127:0] rk0[11];
  logic [127:0] rk1[11];
  logic [7:0]   sbox[256];
  bit           ksel = 1'b0;

  aes_inv_cipher_iter dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_in   (data_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_out  (data_out),
    .rk_idx    (rk_idx),
    .rk_data   (rk_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always_comb begin
    rk_data = '0;
    if (rk_idx <= 4'd10) rk_data = ksel ? rk1[rk_idx] : rk0[rk_idx];
  end

  always @(posedge clk) begin
    if (!rst && in_valid && in_ready) acc_cnt++;
    if (!rst && out_valid && out_ready) ohs_cnt++;
  end

  function automatic logic [127:0] rev(input logic [127:0] x);
    logic [127:0] y;
    for (int i = 0; i < 16; i++) y[8*i +: 8] = x[8*(15-i) +: 8];
    return y;
  endfunction

  function automatic logic [7:0] mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
    end
    return p;
  endfunction

  // Forward S-box from the field inverse plus affine map.
  task automatic build_sbox();
    for (int v = 0; v < 256; v++) begin
      logic [7:0] b;
      logic [7:0] iv;
      b  = 8'(v);
      iv = 8'h00;
      if (v != 0) begin
        iv = 8'h01;
        for (int k = 0; k < 254; k++) iv = mul(iv, b);
      end
      sbox[v] = iv ^ {iv[6:0], iv[7]} ^ {iv[5:0], iv[7:6]}
              ^ {iv[4:0], iv[7:5]} ^ {iv[3:0], iv[7:4]} ^ 8'h63;
    end
  endtask

  task automatic expand(input logic [127:0] key, input bit which);
    logic [31:0] w[44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
        t[31:24] = t[31:24] ^ rc;
        rc = mul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) begin
      if (which) rk1[r] = rev({w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]});
      else       rk0[r] = rev({w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]});
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [127:0] ct, input logic [127:0] pt,
                      output int waited);
    waited = 0;
    in_valid = 1'b1;
    data_in  = ct;
    while (!in_ready && waited < 40) begin
      tick();
      waited++;
    end
    exp_q.push_back(pt);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int n);
    n = 0;
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic take(output logic [127:0] got);
    got = data_out;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic pop_exp(output logic [127:0] e, output bit ok);
    ok = exp_q.size() > 0;
    e  = ok ? exp_q.pop_front() : 128'hx;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL rst_in_ready got %b want 1", in_ready);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL rst_out_valid got %b want 0", out_valid);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL rst_busy got %b want 0", busy);
    end
    checks++;
    if (data_out !== 128'h0) begin
      errors++; $display("FAIL rst_data_out got %h want 0", data_out);
    end
    checks++;
    if (rk_idx !== 4'd10) begin
      errors++; $display("FAIL rst_rk_idx got %0d want 10", rk_idx);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_fips();
    int n;
    logic [3:0] want;
    logic [127:0] got, e;
    bit ok;
    ksel = 1'b1;
    in_valid = 1'b1;
    data_in  = rev(CT1);
    checks++;
    if (rk_idx !== 4'd10 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL fips_accept rk_idx %0d in_ready %b want 10 1", rk_idx, in_ready);
    end
    exp_q.push_back(rev(PT1));
    tick();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 40) begin
      want = (n < 9) ? 4'(9 - n) : 4'd0;
      checks++;
      if (rk_idx !== want) begin
        errors++; $display("FAIL rk_trace step %0d got %0d want %0d", n, rk_idx, want);
      end
      tick();
      n++;
    end
    checks++;
    if (n != 10) begin
      errors++; $display("FAIL fips_latency got %0d edges want 10", n);
    end
    checks++;
    if (rk_idx !== 4'd0 || busy !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL fips_done rk %0d busy %b rdy %b want 0 1 0", rk_idx, busy, in_ready);
    end
    take(got);
    pop_exp(e, ok);
    checks++;
    if (!ok || got !== e) begin
      errors++; $display("FAIL fips_data got %h want %h", got, e);
    end
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL fips_after ov %b rdy %b want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_back_to_back();
    int n, w;
    logic [127:0] got, e;
    bit ok;
    ksel = 1'b0;
    send(rev(CT0), rev(PT0), w);
    wait_out(n);
    checks++;
    if (n != 10) begin
      errors++; $display("FAIL zero_latency got %0d want 10", n);
    end
    take(got);
    pop_exp(e, ok);
    checks++;
    if (!ok || got !== e) begin
      errors++; $display("FAIL zero_data got %h want %h", got, e);
    end
    ksel = 1'b1;
    send(rev(CT1), rev(PT1), w);
    checks++;
    if (w != 0) begin
      errors++; $display("FAIL b2b_accept_wait got %0d want 0", w);
    end
    wait_out(n);
    checks++;
    if (n != 10) begin
      errors++; $display("FAIL b2b_latency got %0d want 10", n);
    end
    take(got);
    pop_exp(e, ok);
    checks++;
    if (!ok || got !== e) begin
      errors++; $display("FAIL b2b_data got %h want %h", got, e);
    end
  endtask

  task automatic test_backpressure();
    int n, w, h0, a0;
    logic [127:0] d0, got, e;
    bit ok;
    ksel = 1'b1;
    send(rev(CT1), rev(PT1), w);
    wait_out(n);
    d0 = data_out;
    h0 = ohs_cnt;
    a0 = acc_cnt;
    for (int i = 0; i < 6; i++) begin
      in_valid = (i % 2 == 0);
      data_in  = {$urandom, $urandom, $urandom, $urandom};
      tick();
      checks++;
      if (out_valid !== 1'b1 || data_out !== d0 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold cyc %0d ov %b rdy %b data %h want 1 0 %h",
                 i, out_valid, in_ready, data_out, d0);
      end
    end
    in_valid = 1'b0;
    take(got);
    pop_exp(e, ok);
    checks++;
    if (!ok || got !== e) begin
      errors++; $display("FAIL bp_data got %h want %h", got, e);
    end
    checks++;
    if (ohs_cnt != h0 + 1 || acc_cnt != a0) begin
      errors++;
      $display("FAIL bp_counts hs %0d acc %0d want %0d %0d", ohs_cnt - h0, acc_cnt - a0, 1, 0);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_idle ov %b busy %b rdy %b want 0 0 1", out_valid, busy, in_ready);
    end
  endtask

  task automatic test_reset_mid();
    int n, w;
    bit pulse;
    logic [127:0] got, e;
    bit ok;
    ksel = 1'b1;
    send(rev(CT1), rev(PT1), w);
    for (int i = 0; i < 4; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    void'(exp_q.pop_back());
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_rst rdy %b busy %b ov %b want 1 0 0", in_ready, busy, out_valid);
    end
    pulse = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (out_valid !== 1'b0) pulse = 1'b1;
      tick();
    end
    checks++;
    if (pulse) begin
      errors++; $display("FAIL mid_rst_pulse got 1 want 0");
    end
    send(rev(CT1), rev(PT1), w);
    wait_out(n);
    checks++;
    if (n != 10) begin
      errors++; $display("FAIL mid_rst_latency got %0d want 10", n);
    end
    take(got);
    pop_exp(e, ok);
    checks++;
    if (!ok || got !== e) begin
      errors++; $display("FAIL mid_rst_data got %h want %h", got, e);
    end
  endtask

  task automatic test_hold_valid();
    int n, a0;
    logic [127:0] got, e;
    bit ok;
    ksel = 1'b1;
    a0 = acc_cnt;
    in_valid = 1'b1;
    data_in  = rev(CT1);
    exp_q.push_back(rev(PT1));
    tick();
    n = 0;
    while (!out_valid && n < 40) begin
      data_in = {$urandom, $urandom, $urandom, $urandom};
      tick();
      n++;
    end
    checks++;
    if (n != 10) begin
      errors++; $display("FAIL hold_latency got %0d want 10", n);
    end
    in_valid = 1'b0;
    take(got);
    pop_exp(e, ok);
    checks++;
    if (!ok || got !== e) begin
      errors++; $display("FAIL hold_data got %h want %h", got, e);
    end
    checks++;
    if (acc_cnt != a0 + 1) begin
      errors++; $display("FAIL hold_accepts got %0d want 1", acc_cnt - a0);
    end
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL hold_idle rdy %b busy %b want 1 0", in_ready, busy);
    end
  endtask

  initial begin
    build_sbox();
    expand(KEY1, 1'b1);
    expand(128'h0, 1'b0);
    test_reset();
    test_fips();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_hold_valid();
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL leftover_expected got %0d want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

endmodule
